// File: rtl/snf_txrsp_lcrd_ctrl.sv
// TXRSP L-credit controller: tracks receiver credits, grants the TXRSP arbiter,
// and on link deactivation returns unused credits as LCrdReturn flits.
module snf_txrsp_lcrd_ctrl #(
   parameter int unsigned CRD_MAX   = 15,
   parameter int unsigned CNT_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 link_run,
   input  logic                 link_deact_req,
   input  logic                 txrsp_lcrdv,
   input  logic                 arb_req,
   output logic                 arb_gnt,
   output logic                 crd_avail,
   output logic                 lcrd_ret_valid,
   input  logic                 lcrd_ret_ready,
   output logic                 lcrd_ret_done,
   output logic [CNT_WIDTH-1:0] crd_cnt,
   output logic                 crd_ovf_err
);

   typedef enum logic [1:0] {
      ST_STOP  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 ovf_q, ovf_d;
   logic                 done_q, done_d;
   logic                 cnt_nz;
   logic                 consume;

   assign cnt_nz = (cnt_q != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_STOP;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      ovf_d          = ovf_q;
      done_d         = done_q;
      arb_gnt        = 1'b0;
      crd_avail      = 1'b0;
      lcrd_ret_valid = 1'b0;
      consume        = 1'b0;

      unique case (state_q)
         ST_STOP: begin
            cnt_d = '0;
            if (link_run && !link_deact_req) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            crd_avail = cnt_nz | txrsp_lcrdv;
            arb_gnt   = arb_req & crd_avail;
            consume   = arb_gnt;
            if (link_deact_req) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            lcrd_ret_valid = cnt_nz | txrsp_lcrdv;
            consume        = lcrd_ret_valid & lcrd_ret_ready;
            if (!cnt_nz && !txrsp_lcrdv) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end
         end
         ST_DONE: begin
            cnt_d = '0;
            if (txrsp_lcrdv) begin
               ovf_d = 1'b1;
            end
            if (!link_deact_req) begin
               state_d = ST_STOP;
               done_d  = 1'b0;
            end
         end
         default: state_d = ST_STOP;
      endcase

      // A consumed credit is either held (cnt_nz) or bypassed from txrsp_lcrdv,
      // so the decrement branch below can never underflow.
      if (state_q == ST_RUN || state_q == ST_DRAIN) begin
         if (txrsp_lcrdv && !consume) begin
            if (cnt_q == CNT_WIDTH'(CRD_MAX)) begin
               ovf_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end else if (!txrsp_lcrdv && consume) begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   assign crd_cnt       = cnt_q;
   assign crd_ovf_err   = ovf_q;
   assign lcrd_ret_done = done_q;

endmodule

// File: tb/tb_snf_txrsp_lcrd_ctrl.sv
// Directed bench for snf_txrsp_lcrd_ctrl: table of per-cycle vectors with
// hand-computed combinational and post-edge expectations, plus short sequences.
module tb_snf_txrsp_lcrd_ctrl;

   logic       clk;
   logic       rst;
   logic       link_run;
   logic       link_deact_req;
   logic       txrsp_lcrdv;
   logic       arb_req;
   logic       arb_gnt;
   logic       crd_avail;
   logic       lcrd_ret_valid;
   logic       lcrd_ret_ready;
   logic       lcrd_ret_done;
   logic [3:0] crd_cnt;
   logic       crd_ovf_err;

   int unsigned n_pass;
   int unsigned n_total;

   typedef struct {
      logic       rst;
      logic       run;
      logic       deact;
      logic       lcrdv;
      logic       req;
      logic       rdy;
      logic       gnt;
      logic       avail;
      logic       rv;
      logic [3:0] cnt;
      logic       ovf;
      logic       done;
   } vec_t;

   vec_t vec_q[$];

   snf_txrsp_lcrd_ctrl #(
      .CRD_MAX  (15),
      .CNT_WIDTH(4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .link_run      (link_run),
      .link_deact_req(link_deact_req),
      .txrsp_lcrdv   (txrsp_lcrdv),
      .arb_req       (arb_req),
      .arb_gnt       (arb_gnt),
      .crd_avail     (crd_avail),
      .lcrd_ret_valid(lcrd_ret_valid),
      .lcrd_ret_ready(lcrd_ret_ready),
      .lcrd_ret_done (lcrd_ret_done),
      .crd_cnt       (crd_cnt),
      .crd_ovf_err   (crd_ovf_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(input string name, input int idx,
                               input logic [7:0] act, input logic [7:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
      end
   endfunction

   function automatic void add(input logic r, input logic run, input logic deact,
                               input logic lcrdv, input logic req, input logic rdy,
                               input logic gnt, input logic avail, input logic rv,
                               input logic [3:0] cnt, input logic ovf, input logic done);
      vec_t v;
      v.rst = r;   v.run = run;     v.deact = deact; v.lcrdv = lcrdv;
      v.req = req; v.rdy = rdy;     v.gnt = gnt;     v.avail = avail;
      v.rv = rv;   v.cnt = cnt;     v.ovf = ovf;     v.done = done;
      vec_q.push_back(v);
   endfunction

   task automatic drive(input logic r, input logic run, input logic deact,
                        input logic lcrdv, input logic req, input logic rdy);
      @(negedge clk);
      rst            = r;
      link_run       = run;
      link_deact_req = deact;
      txrsp_lcrdv    = lcrdv;
      arb_req        = req;
      lcrd_ret_ready = rdy;
      #1;
   endtask

   task automatic apply(input vec_t v, input int idx);
      drive(v.rst, v.run, v.deact, v.lcrdv, v.req, v.rdy);
      chk("arb_gnt", idx, {7'd0, arb_gnt}, {7'd0, v.gnt});
      chk("crd_avail", idx, {7'd0, crd_avail}, {7'd0, v.avail});
      chk("lcrd_ret_valid", idx, {7'd0, lcrd_ret_valid}, {7'd0, v.rv});
      @(posedge clk);
      #1;
      chk("crd_cnt", idx, {4'd0, crd_cnt}, {4'd0, v.cnt});
      chk("crd_ovf_err", idx, {7'd0, crd_ovf_err}, {7'd0, v.ovf});
      chk("lcrd_ret_done", idx, {7'd0, lcrd_ret_done}, {7'd0, v.done});
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;

      //   rst run dea lcv req rdy | gnt avl rv  cnt ovf done
      // STOP ignores credits; enter RUN, accumulate 3 credits
      add(0, 1, 0, 1, 0, 0,   0, 0, 0, 4'd0, 0, 0);
      add(0, 1, 0, 1, 0, 0,   0, 1, 0, 4'd1, 0, 0);
      add(0, 1, 0, 1, 0, 0,   0, 1, 0, 4'd2, 0, 0);
      add(0, 1, 0, 1, 0, 0,   0, 1, 0, 4'd3, 0, 0);
      add(0, 1, 0, 0, 0, 0,   0, 1, 0, 4'd3, 0, 0);
      // spend them; no grant and no underflow at zero
      add(0, 1, 0, 0, 1, 0,   1, 1, 0, 4'd2, 0, 0);
      add(0, 1, 0, 0, 1, 0,   1, 1, 0, 4'd1, 0, 0);
      add(0, 1, 0, 0, 1, 0,   1, 1, 0, 4'd0, 0, 0);
      add(0, 1, 0, 0, 1, 0,   0, 0, 0, 4'd0, 0, 0);
      // bypass grant at zero count
      add(0, 1, 0, 1, 1, 0,   1, 1, 0, 4'd0, 0, 0);
      for (int i = 1; i <= 15; i++) begin
         add(0, 1, 0, 1, 0, 0,   0, 1, 0, 4'(i), 0, 0);
      end
      // overflow at CRD_MAX, then sticky
      add(0, 1, 0, 1, 0, 0,   0, 1, 0, 4'd15, 1, 0);
      add(0, 1, 0, 1, 1, 0,   1, 1, 0, 4'd15, 1, 0);
      for (int i = 14; i >= 5; i--) begin
         add(0, 1, 0, 0, 1, 0,   1, 1, 0, 4'(i), 1, 0);
      end
      // deactivate: grant still honoured in the RUN->DRAIN cycle
      add(0, 1, 1, 0, 1, 1,   1, 1, 0, 4'd4, 1, 0);
      // drain 4 credits with ready 1,0,1,1,1; arbiter request ignored
      add(0, 1, 1, 0, 1, 1,   0, 0, 1, 4'd3, 1, 0);
      add(0, 1, 1, 0, 1, 0,   0, 0, 1, 4'd3, 1, 0);
      add(0, 1, 1, 0, 1, 1,   0, 0, 1, 4'd2, 1, 0);
      add(0, 1, 1, 0, 1, 1,   0, 0, 1, 4'd1, 1, 0);
      add(0, 1, 1, 0, 1, 1,   0, 0, 1, 4'd0, 1, 0);
      add(0, 1, 1, 0, 1, 1,   0, 0, 0, 4'd0, 1, 1);
      add(0, 1, 1, 0, 1, 1,   0, 0, 0, 4'd0, 1, 1);
      add(0, 0, 0, 0, 0, 0,   0, 0, 0, 4'd0, 1, 0);
      // reset clears sticky error; re-enter RUN with 1 credit then DRAIN
      add(1, 0, 0, 0, 0, 0,   0, 0, 0, 4'd0, 0, 0);
      add(0, 1, 0, 0, 0, 0,   0, 0, 0, 4'd0, 0, 0);
      add(0, 1, 0, 1, 0, 0,   0, 1, 0, 4'd1, 0, 0);
      add(0, 1, 1, 0, 0, 0,   0, 1, 0, 4'd1, 0, 0);
      // arriving credit offsets the returned one; DONE not entered
      add(0, 1, 1, 1, 0, 1,   0, 0, 1, 4'd1, 0, 0);
      add(0, 1, 1, 1, 0, 1,   0, 0, 1, 4'd1, 0, 0);
      add(0, 1, 1, 1, 0, 0,   0, 0, 1, 4'd2, 0, 0);
      // reset mid-DRAIN discards credits
      add(1, 1, 1, 1, 0, 0,   0, 0, 1, 4'd0, 0, 0);
      add(0, 1, 1, 1, 1, 1,   0, 0, 0, 4'd0, 0, 0);
      // lcrdv in DONE flags overflow; bypass return at zero holds DRAIN
      add(0, 1, 0, 0, 0, 0,   0, 0, 0, 4'd0, 0, 0);
      add(0, 1, 0, 1, 0, 0,   0, 1, 0, 4'd1, 0, 0);
      add(0, 1, 1, 0, 0, 1,   0, 1, 0, 4'd1, 0, 0);
      add(0, 1, 1, 0, 0, 1,   0, 0, 1, 4'd0, 0, 0);
      add(0, 1, 1, 1, 0, 1,   0, 0, 1, 4'd0, 0, 0);
      add(0, 1, 1, 0, 0, 1,   0, 0, 0, 4'd0, 0, 1);
      add(0, 1, 1, 1, 0, 0,   0, 0, 0, 4'd0, 1, 1);
      add(0, 0, 0, 0, 0, 0,   0, 0, 0, 4'd0, 1, 0);
      add(0, 0, 0, 1, 1, 1,   0, 0, 0, 4'd0, 1, 0);

      // initial reset held for two edges
      drive(1, 0, 0, 0, 0, 0);
      @(posedge clk);
      drive(1, 0, 0, 0, 0, 0);
      chk("reset_gnt", 0, {7'd0, arb_gnt}, 8'd0);
      chk("reset_avail", 0, {7'd0, crd_avail}, 8'd0);
      chk("reset_rv", 0, {7'd0, lcrd_ret_valid}, 8'd0);
      @(posedge clk);
      #1;
      chk("reset_cnt", 0, {4'd0, crd_cnt}, 8'd0);
      chk("reset_ovf", 0, {7'd0, crd_ovf_err}, 8'd0);
      chk("reset_done", 0, {7'd0, lcrd_ret_done}, 8'd0);

      for (int i = 0; i < vec_q.size(); i++) begin
         apply(vec_q[i], i);
      end

      // extended stall: valid holds and count stays while ready is low
      drive(1, 0, 0, 0, 0, 0);
      @(posedge clk);
      drive(0, 1, 0, 0, 0, 0);
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         drive(0, 1, 0, 1, 0, 0);
         @(posedge clk);
      end
      drive(0, 1, 1, 0, 0, 0);
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, 1, 0, 0, 0);
         chk("stall_rv", 100 + i, {7'd0, lcrd_ret_valid}, 8'd1);
         @(posedge clk);
         #1;
         chk("stall_cnt", 100 + i, {4'd0, crd_cnt}, 8'd2);
      end
      for (int i = 0; i < 2; i++) begin
         drive(0, 1, 1, 0, 0, 1);
         @(posedge clk);
      end
      drive(0, 1, 1, 0, 0, 1);
      chk("stall_rv_empty", 110, {7'd0, lcrd_ret_valid}, 8'd0);
      @(posedge clk);
      #1;
      chk("stall_done", 110, {7'd0, lcrd_ret_done}, 8'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/snf_txrsp_lcrd_ctrl.md
Name: snf_txrsp_lcrd_ctrl

Overview:
- L-credit controller for the SNF TXRSP link channel.
- Owns the TXRSP credit counter and grants credits to the TXRSP flit arbiter.
- On link deactivation, drains unused credits back to the receiver as LCrdReturn flits, then reports completion to the SNF link state machine.

Parameters:
- CRD_MAX, 15: maximum L-credits the receiver may grant; range 1..(2^CNT_WIDTH - 1).
- CNT_WIDTH, 4: credit counter width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- link_run  input  1  level from link FSM; TX link is in RUN.
- link_deact_req  input  1  level from link FSM; TX link is entering DEACTIVATE.
- txrsp_lcrdv  input  1  one L-credit received this cycle.
- arb_req  input  1  TXRSP arbiter has a flit to send this cycle.
- arb_gnt  output  1  credit granted; the flit is sent this cycle (combinational).
- crd_avail  output  1  a credit is usable this cycle (combinational).
- lcrd_ret_valid  output  1  request to send a RespLCrdReturn flit (combinational).
- lcrd_ret_ready  input  1  flit slot accepted the LCrdReturn.
- lcrd_ret_done  output  1  drain complete (registered level).
- crd_cnt  output  CNT_WIDTH  current credit count (registered).
- crd_ovf_err  output  1  sticky credit-overflow error (registered).

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: state=STOP, crd_cnt=0, crd_ovf_err=0, lcrd_ret_done=0. All combinational outputs evaluate to 0 in STOP.
- Reset asserted mid-operation (including mid-DRAIN) forces the reset values on the next edge. Outstanding credits are discarded.
- States: STOP, RUN, DRAIN, DONE (2-bit encoded).
- STOP:
  - txrsp_lcrdv is ignored and crd_cnt is held at 0.
  - STOP->RUN when link_run=1 and link_deact_req=0.
- RUN:
  - crd_avail = (crd_cnt!=0) | txrsp_lcrdv.
  - arb_gnt = arb_req & crd_avail.
  - crd_cnt next = crd_cnt + txrsp_lcrdv - arb_gnt.
  - Simultaneous lcrdv and gnt: count holds. Bypass use of a credit arriving this cycle is legal; zero-latency use.
  - Overflow: crd_cnt==CRD_MAX and lcrdv=1 and arb_gnt=0 → count holds at CRD_MAX and crd_ovf_err sets. Once set, it is cleared only by rst.
  - RUN->DRAIN when link_deact_req=1. This takes precedence over link_run; arb_gnt is still evaluated in that cycle.
- DRAIN:
  - arb_gnt=0 and crd_avail=0.
  - lcrd_ret_valid = (crd_cnt!=0) | txrsp_lcrdv.
  - Credit consumed (ret) = lcrd_ret_valid & lcrd_ret_ready.
  - crd_cnt next = crd_cnt + txrsp_lcrdv - ret, with the same overflow rule as RUN.
  - lcrd_ret_valid may assert when lcrd_ret_ready=0; it must hold until accepted or until the count reaches 0.
  - DRAIN->DONE when crd_cnt==0 and txrsp_lcrdv=0 in the same cycle.
- DONE:
  - lcrd_ret_done=1.
  - txrsp_lcrdv arriving in DONE sets crd_ovf_err; the count stays 0.
  - DONE->STOP when link_deact_req=0. lcrd_ret_done clears on the STOP entry edge.
- Arithmetic: crd_cnt never underflows; decrement occurs only when crd_cnt!=0 or the credit is bypassed. Width is CNT_WIDTH, unsigned.
- No other outputs change state outside these rules.

Test Plan:
1. Reset then link_run=1. Pulse txrsp_lcrdv 3 cycles, arb_req=0 → crd_cnt=3, crd_avail=1, no arb_gnt.
2. RUN, crd_cnt=0. Drive txrsp_lcrdv=1 and arb_req=1 together → arb_gnt=1 that cycle; crd_cnt stays 0.
3. RUN, crd_cnt=15 (CRD_MAX). Drive txrsp_lcrdv=1, arb_req=0 → crd_cnt stays 15; crd_ovf_err=1 next cycle, sticky until rst.
4. RUN, crd_cnt=4. Assert link_deact_req; lcrd_ret_ready toggles 1,0,1,1,1 → 4 LCrdReturns are accepted on the ready cycles, with the stall cycle honoured. Then crd_cnt=0, state DONE, lcrd_ret_done=1. Deassert link_deact_req → lcrd_ret_done=0, state STOP.
5. DRAIN, crd_cnt=1, txrsp_lcrdv=1, lcrd_ret_ready=1 → crd_cnt stays 1. DONE is not entered until a cycle with crd_cnt==0 and lcrdv=0.
6. DRAIN, crd_cnt=2. Assert rst for 1 cycle → next cycle crd_cnt=0, state STOP, lcrd_ret_valid=0, crd_ovf_err=0.
